// File: rtl/fb_write_arbiter.sv
// Round-robin owner of the single framebuffer write port. One engine holds the port
// from grant until it pulses done (or the hold watchdog fires); its writes pass through one register stage.
module fb_write_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 3,
  parameter int ID_W     = 2,
  parameter int MAX_HOLD = 65536
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        done,
  input  logic [NUM_REQ*ADDR_W-1:0] req_waddr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  input  logic [NUM_REQ-1:0]        req_wenable,
  output logic [NUM_REQ-1:0]        grant,
  output logic [ID_W-1:0]           active_id,
  output logic                      busy,
  output logic [ADDR_W-1:0]         mem_waddr,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic                      mem_wenable,
  output logic                      timeout_err
);

  localparam int CNT_W = $clog2(MAX_HOLD) + 1;

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t               state;
  logic [ID_W-1:0]      rr_ptr;
  logic [CNT_W-1:0]     hold_cnt;

  logic [2*NUM_REQ-1:0] req_rot;
  logic [ID_W-1:0]      sel_id;
  logic                 sel_valid;
  logic [NUM_REQ-1:0]   sel_onehot;
  logic [ID_W-1:0]      next_ptr;
  logic                 hold_expired;

  logic [ADDR_W-1:0]    g_waddr;
  logic [DATA_W-1:0]    g_wdata;
  logic                 g_wenable;
  logic                 g_done;

  // Rotate the request vector so bit 0 is the pointer slot; the lowest set bit wins.
  always_comb begin
    int off;
    int tmp;
    off       = 0;
    tmp       = 0;
    sel_valid = 1'b0;
    req_rot   = {req, req} >> rr_ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        off       = k;
        sel_valid = 1'b1;
      end
    end
    tmp = int'(rr_ptr) + off;
    if (tmp >= NUM_REQ) tmp = tmp - NUM_REQ;
    sel_id = ID_W'(tmp);
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_onehot[i] = (sel_id == ID_W'(i));
    end
  end

  always_comb begin
    g_waddr   = '0;
    g_wdata   = '0;
    g_wenable = 1'b0;
    g_done    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        g_waddr   = req_waddr[i*ADDR_W +: ADDR_W];
        g_wdata   = req_wdata[i*DATA_W +: DATA_W];
        g_wenable = req_wenable[i];
        g_done    = done[i];
      end
    end
  end

  assign next_ptr     = (active_id == ID_W'(NUM_REQ - 1)) ? '0 : active_id + 1'b1;
  assign hold_expired = (hold_cnt == CNT_W'(MAX_HOLD - 1));
  assign busy         = |grant;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      hold_cnt    <= '0;
      grant       <= '0;
      active_id   <= '0;
      mem_waddr   <= '0;
      mem_wdata   <= '0;
      mem_wenable <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          mem_wenable <= 1'b0;
          if (sel_valid) begin
            grant     <= sel_onehot;
            active_id <= sel_id;
            hold_cnt  <= '0;
            state     <= GRANT;
          end
        end
        GRANT: begin
          // The release-edge write is still forwarded so a done-cycle write lands.
          mem_waddr   <= g_waddr;
          mem_wdata   <= g_wdata;
          mem_wenable <= g_wenable;
          if (g_done || hold_expired) begin
            grant  <= '0;
            rr_ptr <= next_ptr;
            state  <= GAP;
            if (hold_expired) timeout_err <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        GAP: begin
          mem_wenable <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          grant       <= '0;
          mem_wenable <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Scoreboard bench for fb_write_arbiter: each forwarded write is queued when driven
// and popped when it appears on the mem_* port.
module tb_fb_write_arbiter;

  localparam int NUM_REQ  = 3;
  localparam int ADDR_W   = 19;
  localparam int DATA_W   = 3;
  localparam int ID_W     = 2;
  localparam int MAX_HOLD = 16;

  logic                      clock = 1'b0;
  logic                      resetn = 1'b1;
  logic [NUM_REQ-1:0]        req = '0;
  logic [NUM_REQ-1:0]        done = '0;
  logic [NUM_REQ*ADDR_W-1:0] req_waddr = '0;
  logic [NUM_REQ*DATA_W-1:0] req_wdata = '0;
  logic [NUM_REQ-1:0]        req_wenable = '0;
  logic [NUM_REQ-1:0]        grant;
  logic [ID_W-1:0]           active_id;
  logic                      busy;
  logic [ADDR_W-1:0]         mem_waddr;
  logic [DATA_W-1:0]         mem_wdata;
  logic                      mem_wenable;
  logic                      timeout_err;

  int checks = 0;
  int failures = 0;
  int writes_seen = 0;
  logic [ADDR_W+DATA_W-1:0] sb_q[$];

  fb_write_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clock(clock), .resetn(resetn), .req(req), .done(done),
    .req_waddr(req_waddr), .req_wdata(req_wdata), .req_wenable(req_wenable),
    .grant(grant), .active_id(active_id), .busy(busy),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wenable(mem_wenable),
    .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  // Every write seen on the memory port must match the oldest expected write.
  always @(negedge clock) begin
    logic [ADDR_W+DATA_W-1:0] exp_w;
    if (mem_wenable === 1'b1) begin
      writes_seen++;
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_write: got addr=%0d data=%0d, expected no write", mem_waddr, mem_wdata);
      end else begin
        exp_w = sb_q.pop_front();
        if ({mem_waddr, mem_wdata} !== exp_w) begin
          failures++;
          $display("[TB] FAIL write_data: got addr=%0d data=%0d, expected addr=%0d data=%0d",
                   mem_waddr, mem_wdata, exp_w[ADDR_W+DATA_W-1:DATA_W], exp_w[DATA_W-1:0]);
        end
      end
    end
  end

  task automatic set_lane(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic we);
    req_waddr[i*ADDR_W +: ADDR_W] = a;
    req_wdata[i*DATA_W +: DATA_W] = d;
    req_wenable[i] = we;
  endtask

  task automatic clear_inputs();
    req = '0;
    done = '0;
    req_waddr = '0;
    req_wdata = '0;
    req_wenable = '0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    clear_inputs();
    resetn = 1'b0;
    sb_q.delete();
    repeat (2) @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clock);
    resetn = 1'b0;
    #1;
    checks++;
    if ({grant, active_id, busy, mem_waddr, mem_wdata, mem_wenable, timeout_err} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got grant=%b id=%0d busy=%b we=%b terr=%b, expected all zero",
               grant, active_id, busy, mem_wenable, timeout_err);
    end
    req = 3'b111;
    @(negedge clock);
    checks++;
    if (grant !== 3'b000) begin
      failures++;
      $display("[TB] FAIL reset_hold_grant: got %b, expected 000", grant);
    end
    req = '0;
    resetn = 1'b1;
  endtask

  task automatic test_single_owner();
    int base;
    do_reset();
    base = writes_seen;
    req = 3'b010;
    @(negedge clock);
    checks++;
    if (grant !== 3'b010 || active_id !== 2'd1 || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL single_grant: got grant=%b id=%0d busy=%b, expected 010 1 1", grant, active_id, busy);
    end
    for (int k = 0; k < 6; k++) begin
      set_lane(1, ADDR_W'(100 + k), 3'b101, 1'b1);
      done[1] = (k == 5);
      sb_q.push_back({ADDR_W'(100 + k), 3'b101});
      @(negedge clock);
      if (k < 5) begin
        checks++;
        if (grant !== 3'b010) begin
          failures++;
          $display("[TB] FAIL single_hold k=%0d: got %b, expected 010", k, grant);
        end
      end
    end
    checks++;
    if (grant !== 3'b000 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_release: got grant=%b busy=%b, expected 000 0", grant, busy);
    end
    clear_inputs();
    @(negedge clock);
    #1;
    checks++;
    if (mem_wenable !== 1'b0 || mem_waddr !== ADDR_W'(105)) begin
      failures++;
      $display("[TB] FAIL single_gap: got we=%b addr=%0d, expected 0 105", mem_wenable, mem_waddr);
    end
    checks++;
    if (writes_seen - base !== 6 || sb_q.size() !== 0) begin
      failures++;
      $display("[TB] FAIL single_count: got %0d writes, %0d pending, expected 6 and 0", writes_seen - base, sb_q.size());
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] rr_exp [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    logic [1:0] id_exp [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
    do_reset();
    req = 3'b111;
    @(negedge clock);
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (grant !== rr_exp[n] || active_id !== id_exp[n]) begin
        failures++;
        $display("[TB] FAIL rr_grant n=%0d: got grant=%b id=%0d, expected %b %0d", n, grant, active_id, rr_exp[n], id_exp[n]);
      end
      repeat (2) @(negedge clock);
      done = rr_exp[n];
      @(negedge clock);
      done = '0;
      if (n == 3) req = '0;
      checks++;
      if (grant !== 3'b000) begin
        failures++;
        $display("[TB] FAIL rr_release n=%0d: got %b, expected 000", n, grant);
      end
      @(negedge clock);
      checks++;
      if (grant !== 3'b000) begin
        failures++;
        $display("[TB] FAIL rr_gap n=%0d: got %b, expected 000", n, grant);
      end
      @(negedge clock);
    end
    checks++;
    if (grant !== 3'b000) begin
      failures++;
      $display("[TB] FAIL rr_idle: got %b, expected 000", grant);
    end
  endtask

  task automatic test_isolation();
    do_reset();
    req = 3'b001;
    set_lane(1, ADDR_W'(7), 3'b110, 1'b1);
    set_lane(2, ADDR_W'(9), 3'b001, 1'b1);
    @(negedge clock);
    checks++;
    if (grant !== 3'b001) begin
      failures++;
      $display("[TB] FAIL iso_grant: got %b, expected 001", grant);
    end
    for (int k = 0; k < 4; k++) begin
      set_lane(0, ADDR_W'(20 + k), k[2:0], 1'b1);
      sb_q.push_back({ADDR_W'(20 + k), k[2:0]});
      done[2] = (k == 1);
      @(negedge clock);
      checks++;
      if (grant !== 3'b001) begin
        failures++;
        $display("[TB] FAIL iso_hold k=%0d: got %b, expected 001", k, grant);
      end
    end
    set_lane(0, ADDR_W'(30), 3'b111, 1'b1);
    sb_q.push_back({ADDR_W'(30), 3'b111});
    done = 3'b001;
    @(negedge clock);
    clear_inputs();
    checks++;
    if (grant !== 3'b000) begin
      failures++;
      $display("[TB] FAIL iso_release: got %b, expected 000", grant);
    end
    @(negedge clock);
    #1;
    checks++;
    if (sb_q.size() !== 0) begin
      failures++;
      $display("[TB] FAIL iso_pending: got %0d writes outstanding, expected 0", sb_q.size());
    end
  endtask

  task automatic test_timeout();
    do_reset();
    req = 3'b100;
    @(negedge clock);
    checks++;
    if (grant !== 3'b100 || active_id !== 2'd2) begin
      failures++;
      $display("[TB] FAIL to_grant: got grant=%b id=%0d, expected 100 2", grant, active_id);
    end
    req = 3'b011;
    for (int k = 1; k < MAX_HOLD; k++) begin
      @(negedge clock);
      checks++;
      if (grant !== 3'b100 || timeout_err !== 1'b0) begin
        failures++;
        $display("[TB] FAIL to_hold k=%0d: got grant=%b terr=%b, expected 100 0", k, grant, timeout_err);
      end
    end
    @(negedge clock);
    checks++;
    if (grant !== 3'b000 || timeout_err !== 1'b1) begin
      failures++;
      $display("[TB] FAIL to_release: got grant=%b terr=%b, expected 000 1", grant, timeout_err);
    end
    @(negedge clock);
    checks++;
    if (grant !== 3'b000) begin
      failures++;
      $display("[TB] FAIL to_gap: got %b, expected 000", grant);
    end
    @(negedge clock);
    checks++;
    if (grant !== 3'b001 || active_id !== 2'd0) begin
      failures++;
      $display("[TB] FAIL to_regrant: got grant=%b id=%0d, expected 001 0", grant, active_id);
    end
    done = 3'b001;
    @(negedge clock);
    done = '0;
    req = '0;
    repeat (2) @(negedge clock);
    checks++;
    if (timeout_err !== 1'b1 || grant !== 3'b000) begin
      failures++;
      $display("[TB] FAIL to_sticky: got terr=%b grant=%b, expected 1 000", timeout_err, grant);
    end
  endtask

  task automatic test_reset_mid_grant();
    req = 3'b010;
    @(negedge clock);
    checks++;
    if (grant !== 3'b010) begin
      failures++;
      $display("[TB] FAIL mid_grant: got %b, expected 010", grant);
    end
    set_lane(1, ADDR_W'(500), 3'b011, 1'b1);
    sb_q.push_back({ADDR_W'(500), 3'b011});
    @(negedge clock);
    set_lane(1, ADDR_W'(0), 3'b000, 1'b0);
    #1;
    checks++;
    if (mem_wenable !== 1'b1 || timeout_err !== 1'b1) begin
      failures++;
      $display("[TB] FAIL mid_pre: got we=%b terr=%b, expected 1 1", mem_wenable, timeout_err);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if (grant !== 3'b000 || busy !== 1'b0 || mem_wenable !== 1'b0 || timeout_err !== 1'b0
        || active_id !== 2'd0 || mem_waddr !== '0) begin
      failures++;
      $display("[TB] FAIL mid_async: got grant=%b busy=%b we=%b terr=%b id=%0d addr=%0d, expected all zero",
               grant, busy, mem_wenable, timeout_err, active_id, mem_waddr);
    end
    req = 3'b110;
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    checks++;
    if (grant !== 3'b010 || active_id !== 2'd1) begin
      failures++;
      $display("[TB] FAIL mid_after: got grant=%b id=%0d, expected 010 1", grant, active_id);
    end
    done = 3'b010;
    req = '0;
    @(negedge clock);
    done = '0;
    @(negedge clock);
    #1;
    checks++;
    if (sb_q.size() !== 0) begin
      failures++;
      $display("[TB] FAIL mid_pending: got %0d writes outstanding, expected 0", sb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_owner();
    test_round_robin();
    test_isolation();
    test_timeout();
    test_reset_mid_grant();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL sim_timeout: got no completion, expected finish before 200000");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

endmodule

// File: doc/fb_write_arbiter.md
Name: fb_write_arbiter

Overview:
- Owns the single framebuffer write port (19-bit pixel address, 3-bit colour index, write enable).
- Shares it between NUM_REQ write engines: text typer, trajectory drawer and screen clear.
- Requesters use a req/done handshake. Grants are round-robin and held until the owner signals done.
- Only the granted engine's writes reach memory, through one register stage. A hold watchdog recovers from an engine that never finishes.

Parameters:
NUM_REQ, 3, number of requesters (2..4)
ADDR_W, 19, framebuffer address width
DATA_W, 3, colour index width
ID_W, 2, width of active_id
MAX_HOLD, 65536, maximum cycles one grant may last before forced release

Ports:
clock  in  1  system clock; all state changes on rising edge
resetn  in  1  asynchronous, active-low reset
req  in  NUM_REQ  per-requester request level
done  in  NUM_REQ  per-requester single-cycle finish pulse
req_waddr  in  NUM_REQ*ADDR_W  packed addresses; requester i at [ADDR_W*i +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  packed data; requester i at [DATA_W*i +: DATA_W]
req_wenable  in  NUM_REQ  per-requester write enable
grant  out  NUM_REQ  one-hot grant; all-zero when idle
active_id  out  ID_W  index of current/last granted requester
busy  out  1  high while any grant is held (equals |grant)
mem_waddr  out  ADDR_W  registered address to framebuffer
mem_wdata  out  DATA_W  registered data to framebuffer
mem_wenable  out  1  registered write enable to framebuffer
timeout_err  out  1  sticky flag: a grant was force-released

Behaviour:
- Reset (resetn=0, asynchronous, effective immediately, also mid-grant):
  - grant=0, active_id=0, busy=0, mem_waddr=0, mem_wdata=0, mem_wenable=0, timeout_err=0.
  - Round-robin pointer=0; hold counter=0; state=IDLE.
- States: IDLE, GRANT, GAP.
- IDLE:
  - If req != 0, select the first set bit scanning from pointer upward, wrapping modulo NUM_REQ.
  - At that edge: grant<=onehot(sel), active_id<=sel, hold counter<=0, state<=GRANT.
  - Latency from req high (IDLE) to grant high: 1 edge.
- GRANT, every edge:
  - mem_waddr<=req_waddr[g], mem_wdata<=req_wdata[g], mem_wenable<=req_wenable[g].
  - Write latency is exactly 1 cycle.
  - Non-granted enables are never forwarded.
- Release conditions, evaluated in GRANT:
  - done[g]=1: release.
  - hold counter == MAX_HOLD-1: release and set timeout_err<=1. timeout_err stays set until reset.
  - done[g] and timeout on the same edge: release and still set timeout_err.
  - Otherwise hold counter increments.
- Release edge:
  - The granted write on that edge is still forwarded (the done-cycle write lands).
  - grant<=0, pointer<=(g+1) mod NUM_REQ, state<=GAP.
- GAP: lasts one cycle; mem_wenable<=0; state<=IDLE. Guarantees a bubble between owners.
- Fastest re-grant: done sampled at edge T, next grant at edge T+2.
- IDLE/GAP outputs: mem_wenable<=0; mem_waddr/mem_wdata hold last value; active_id holds.
- Ignored inputs:
  - done from non-granted requesters, and done in IDLE/GAP.
  - req dropping while granted: the grant persists until done or timeout.
- Simultaneous requests: round-robin only, no fixed priority.
- Fairness: with all requesters always requesting, grants rotate 0,1,2,0…

Test Plan:
- Single owner:
  - Stimulus: reset, then req=3'b010; requester 1 drives 5 writes (addresses 100..104, data 3'b101), then pulses done with a write to 105.
  - Required: grant=3'b010 one edge after req; mem_* mirror each input one cycle later; six writes total; grant=0 at the release edge; mem_wenable=0 during GAP.
- Round-robin:
  - Stimulus: req=3'b111 held, each owner pulses done 3 cycles after its grant.
  - Required: grant sequence 001,010,100,001; active_id 0,1,2,0; exactly one GAP cycle between grants.
- Isolation:
  - Stimulus: requester 0 granted while requesters 1 and 2 drive wenable=1 with addresses 7 and 9.
  - Required: mem_waddr never 7 or 9; only requester 0 traffic appears; done[2] pulse ignored.
- Timeout (MAX_HOLD=16):
  - Stimulus: requester 2 granted, never asserts done.
  - Required: release 16 edges after grant; timeout_err=1 and stays 1; pointer moves to 0; next pending requester granted at release+2.
- Reset mid-grant:
  - Stimulus: resetn low for one cycle while requester 1 writes.
  - Required: grant, mem_wenable and timeout_err go to 0 immediately, without waiting for a clock edge; after release, req=3'b110 grants requester 1 first (pointer reset to 0, scan upward).
